// File: rtl/core_axi_master.sv
// Single-outstanding AXI4-Lite master: turns one load/store request into one
// AXI4-Lite read or write and returns a one-cycle completion pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a request; misaligned requests answered from here
//   RD_ADDR | arvalid high, waiting for arready
//   RD_DATA | rready high, waiting for rvalid
//   WR_REQ  | awvalid/wvalid issued, waiting for both handshakes
//   WR_RESP | bready high, waiting for bvalid
//   RESP    | result captured; resp_valid fires on the way back to IDLE
module core_axi_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,

   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,

   output logic [ADDR_W-1:0]   axi_araddr,
   output logic                axi_arvalid,
   input  logic                axi_arready,

   input  logic [DATA_W-1:0]   axi_rdata,
   input  logic [1:0]          axi_rresp,
   input  logic                axi_rvalid,
   output logic                axi_rready,

   output logic [ADDR_W-1:0]   axi_awaddr,
   output logic                axi_awvalid,
   input  logic                axi_awready,

   output logic [DATA_W-1:0]   axi_wdata,
   output logic [DATA_W/8-1:0] axi_wstrb,
   output logic                axi_wvalid,
   input  logic                axi_wready,

   input  logic [1:0]          axi_bresp,
   input  logic                axi_bvalid,
   output logic                axi_bready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      RESP    = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic              accept;
   logic              misaligned;
   logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic              aw_done, w_done;
   logic              wr_both;
   logic              r_err, b_err;
   logic [DATA_W-1:0] pend_rdata;
   logic              pend_err;

   assign req_ready  = (state == IDLE) && !resp_valid;
   assign accept     = req_valid && req_ready;
   assign misaligned = (req_addr[1:0] != 2'b00);

   assign ar_hs = axi_arvalid && axi_arready;
   assign r_hs  = axi_rvalid  && axi_rready;
   assign aw_hs = axi_awvalid && axi_awready;
   assign w_hs  = axi_wvalid  && axi_wready;
   assign b_hs  = axi_bvalid  && axi_bready;

   // Either channel may finish first, or both in the same cycle.
   assign wr_both = (aw_done || aw_hs) && (w_done || w_hs);

   // SLVERR and DECERR both count as failures.
   assign r_err = (axi_rresp == 2'b10) || (axi_rresp == 2'b11);
   assign b_err = (axi_bresp == 2'b10) || (axi_bresp == 2'b11);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && !misaligned) begin
               state_nxt = req_we ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (ar_hs) begin
               state_nxt = RD_DATA;
            end
         end
         RD_DATA: begin
            if (r_hs) begin
               state_nxt = RESP;
            end
         end
         WR_REQ: begin
            if (wr_both) begin
               state_nxt = WR_RESP;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The AXI payload registers double as the request latch, so they only
   // change on an aligned acceptance and stay put while their valid is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         axi_araddr  <= '0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
         axi_awaddr  <= '0;
         axi_awvalid <= 1'b0;
         axi_wdata   <= '0;
         axi_wstrb   <= '0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         pend_rdata  <= '0;
         pend_err    <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
      end else begin
         resp_valid <= 1'b0;

         if (accept) begin
            if (misaligned) begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               resp_rdata <= '0;
            end else if (req_we) begin
               axi_awaddr  <= req_addr;
               axi_wdata   <= req_wdata;
               axi_wstrb   <= req_wstrb;
               axi_awvalid <= 1'b1;
               axi_wvalid  <= 1'b1;
               aw_done     <= 1'b0;
               w_done      <= 1'b0;
            end else begin
               axi_araddr  <= req_addr;
               axi_arvalid <= 1'b1;
            end
         end

         if (ar_hs) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
         end

         if (r_hs) begin
            axi_rready <= 1'b0;
            pend_err   <= r_err;
            pend_rdata <= r_err ? '0 : axi_rdata;
         end

         if (aw_hs) begin
            axi_awvalid <= 1'b0;
            aw_done     <= 1'b1;
         end

         if (w_hs) begin
            axi_wvalid <= 1'b0;
            w_done     <= 1'b1;
         end

         if ((state == WR_REQ) && wr_both) begin
            axi_bready <= 1'b1;
         end

         if (b_hs) begin
            axi_bready <= 1'b0;
            pend_err   <= b_err;
            pend_rdata <= '0;
         end

         // Response outputs only move when a completion is published.
         if (state == RESP) begin
            resp_valid <= 1'b1;
            resp_rdata <= pend_rdata;
            resp_err   <= pend_err;
         end
      end
   end

endmodule

// File: tb/tb_core_axi_master.sv
// Bench for core_axi_master: configurable AXI4-Lite slave, handshake observer
// and a response scoreboard fed with hand-computed expectations.
module tb_core_axi_master;

   logic        clk;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
   logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
   logic        axi_bvalid, axi_bready;
   logic [1:0]  axi_rresp, axi_bresp;
   logic [3:0]  axi_wstrb;

   core_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
      .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
      .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // slave configuration
   int          s_ar_dly, s_r_dly, s_aw_dly, s_w_dly, s_b_dly;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;
   int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

   // observer results for the current transaction
   int          ar_hi, aw_hi, w_hi, resp_cnt, resp_cyc;
   int          aw_hs_cyc, w_hs_cyc, b_rise_cyc, viol;
   logic [31:0] ar_hs_addr, aw_hs_addr, w_hs_data;
   logic [3:0]  w_hs_strb;
   logic        p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs;
   logic [31:0] p_araddr, p_awaddr, p_wdata;
   logic [3:0]  p_wstrb;

   task automatic set_slave(input int ar, input int r, input int aw, input int w, input int b,
                            input logic [31:0] rdata, input logic [1:0] rresp,
                            input logic [1:0] bresp);
      s_ar_dly = ar; s_r_dly = r; s_aw_dly = aw; s_w_dly = w; s_b_dly = b;
      s_rdata = rdata; s_rresp = rresp; s_bresp = bresp;
   endtask

   task automatic clear_obs();
      ar_hi = 0; aw_hi = 0; w_hi = 0; resp_cnt = 0; resp_cyc = -1;
      aw_hs_cyc = -1; w_hs_cyc = -1; b_rise_cyc = -1; viol = 0;
      ar_hs_addr = '0; aw_hs_addr = '0; w_hs_data = '0; w_hs_strb = '0;
   endtask

   // Slave drives at the falling edge; the values then hold through the next
   // rising edge, so a handshake seen here is the one that rising edge takes.
   initial begin
      axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      p_arv = 0; p_arhs = 0; p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0;
      p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
      clear_obs();
      forever begin
         @(negedge clk);
         if (rst) begin
            axi_arready = 0; axi_rvalid = 0; axi_rdata = 0;
            axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            p_arv = 0; p_awv = 0; p_wv = 0;
         end else begin
            if (axi_arvalid) begin axi_arready = (ar_cnt >= s_ar_dly); ar_cnt++; end
            else begin axi_arready = 0; ar_cnt = 0; end
            if (axi_rready) begin
               axi_rvalid = (r_cnt >= s_r_dly); axi_rdata = s_rdata; axi_rresp = s_rresp; r_cnt++;
            end else begin axi_rvalid = 0; axi_rdata = 0; r_cnt = 0; end
            if (axi_awvalid) begin axi_awready = (aw_cnt >= s_aw_dly); aw_cnt++; end
            else begin axi_awready = 0; aw_cnt = 0; end
            if (axi_wvalid) begin axi_wready = (w_cnt >= s_w_dly); w_cnt++; end
            else begin axi_wready = 0; w_cnt = 0; end
            if (axi_bready) begin axi_bvalid = (b_cnt >= s_b_dly); axi_bresp = s_bresp; b_cnt++; end
            else begin axi_bvalid = 0; b_cnt = 0; end

            // a pending valid must stay high with a frozen payload
            if (p_arv && !p_arhs && (!axi_arvalid || axi_araddr !== p_araddr)) viol++;
            if (p_awv && !p_awhs && (!axi_awvalid || axi_awaddr !== p_awaddr)) viol++;
            if (p_wv && !p_whs && (!axi_wvalid || axi_wdata !== p_wdata || axi_wstrb !== p_wstrb)) viol++;

            if (axi_arvalid) ar_hi++;
            if (axi_awvalid) aw_hi++;
            if (axi_wvalid)  w_hi++;
            if (axi_arvalid && axi_arready) ar_hs_addr = axi_araddr;
            if (axi_awvalid && axi_awready) begin aw_hs_cyc = cyc + 1; aw_hs_addr = axi_awaddr; end
            if (axi_wvalid && axi_wready) begin
               w_hs_cyc = cyc + 1; w_hs_data = axi_wdata; w_hs_strb = axi_wstrb;
            end
            if (axi_bready && b_rise_cyc < 0) b_rise_cyc = cyc;
            if (resp_valid) begin resp_cnt++; resp_cyc = cyc; end

            p_arv = axi_arvalid; p_arhs = axi_arvalid && axi_arready; p_araddr = axi_araddr;
            p_awv = axi_awvalid; p_awhs = axi_awvalid && axi_awready; p_awaddr = axi_awaddr;
            p_wv = axi_wvalid; p_whs = axi_wvalid && axi_wready;
            p_wdata = axi_wdata; p_wstrb = axi_wstrb;
         end
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && resp_valid) begin
            check("sb_expected_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
               check("resp_err", 64'(resp_err), 64'(e.err));
            end
         end
      end
   end

   int acc_cyc;

   task automatic wait_ready(input string tag, output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (req_ready) begin ok = 1; break; end
      end
      check({tag, " req_ready_wait"}, 64'(ok), 64'd1);
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
      @(posedge clk); #1;
      acc_cyc = cyc;
      // scramble the inputs to prove they were latched
      req_valid = 0; req_we = ~we; req_addr = 32'h0BAD_0BA0;
      req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'h0;
   endtask

   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      exp_t e;
      bit   ok;
      bit   got;
      clear_obs();
      wait_ready(tag, ok);
      if (ok) begin
         e.rdata = exp_rdata; e.err = exp_err;
         sb_q.push_back(e);
         issue(we, addr, wdata, wstrb);
         got = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (resp_cnt != 0) begin got = 1; break; end
         end
         check({tag, " resp_seen"}, 64'(got), 64'd1);
         if (got) begin
            check({tag, " latency"}, 64'(resp_cyc - acc_cyc + 1), 64'(exp_lat));
            @(negedge clk); #1;
            check({tag, " ready_after_resp"}, 64'(req_ready), 64'd1);
            repeat (3) @(negedge clk);
            #1;
            check({tag, " single_pulse"}, 64'(resp_cnt), 64'd1);
            check({tag, " valid_stability"}, 64'(viol), 64'd0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit found;
      rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
      #1;
      check("rst req_ready", 64'(req_ready), 64'd1);
      check("rst valids", 64'({axi_arvalid, axi_awvalid, axi_wvalid}), 64'd0);
      check("rst readys", 64'({axi_rready, axi_bready}), 64'd0);
      check("rst resp", 64'({resp_valid, resp_err}), 64'd0);
      check("rst resp_rdata", 64'(resp_rdata), 64'd0);
      check("rst addrs", 64'({axi_araddr, axi_awaddr}), 64'd0);
      check("rst wdata_wstrb", 64'({axi_wdata, axi_wstrb}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 0;

      // basic read, slave as fast as possible
      set_slave(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00);
      do_req("rd_basic", 0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 4);
      check("rd_basic arvalid_cycles", 64'(ar_hi), 64'd1);
      check("rd_basic araddr_at_hs", 64'(ar_hs_addr), 64'h10);
      check("rd_basic no_write", 64'(aw_hi + w_hi), 64'd0);

      // write with awready delayed 3 cycles, wready immediate
      set_slave(0, 0, 3, 0, 0, 32'h0, 2'b00, 2'b00);
      do_req("wr_aw_slow", 1, 32'hFF00_0004, 32'h41, 4'hF, 32'h0, 0, 7);
      check("wr_aw_slow w_before_aw", 64'(w_hs_cyc < aw_hs_cyc), 64'd1);
      check("wr_aw_slow awvalid_cycles", 64'(aw_hi), 64'd4);
      check("wr_aw_slow wvalid_cycles", 64'(w_hi), 64'd1);
      check("wr_aw_slow bready_rise", 64'(b_rise_cyc), 64'(aw_hs_cyc));
      check("wr_aw_slow awaddr", 64'(aw_hs_addr), 64'hFF00_0004);
      check("wr_aw_slow wdata_wstrb", 64'({w_hs_data, w_hs_strb}), 64'h41F);

      // read error: SLVERR, slow arready and rvalid
      set_slave(2, 1, 0, 0, 0, 32'h1234_5678, 2'b10, 2'b00);
      do_req("rd_slverr", 0, 32'h0000_0100, 32'h0, 4'h0, 32'h0, 1, 7);
      check("rd_slverr arvalid_cycles", 64'(ar_hi), 64'd3);

      // write error: DECERR, both handshakes in the same cycle
      set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b11);
      do_req("wr_decerr", 1, 32'h0000_0200, 32'hA5A5_A5A5, 4'h3, 32'h0, 1, 4);
      check("wr_decerr simultaneous", 64'(aw_hs_cyc), 64'(w_hs_cyc));
      check("wr_decerr bready_rise", 64'(b_rise_cyc), 64'(w_hs_cyc));

      // write with wready delayed 2 and bvalid delayed 1
      set_slave(0, 0, 0, 2, 1, 32'h0, 2'b00, 2'b00);
      do_req("wr_w_slow", 1, 32'h0000_0300, 32'h5555_AAAA, 4'hC, 32'h0, 0, 7);
      check("wr_w_slow aw_before_w", 64'(aw_hs_cyc < w_hs_cyc), 64'd1);
      check("wr_w_slow bready_rise", 64'(b_rise_cyc), 64'(w_hs_cyc));
      check("wr_w_slow wvalid_cycles", 64'(w_hi), 64'd3);

      // misaligned read and write rejected locally
      set_slave(0, 0, 0, 0, 0, 32'h7777_7777, 2'b00, 2'b00);
      do_req("rd_misaligned", 0, 32'h0000_0003, 32'h0, 4'h0, 32'h0, 1, 1);
      check("rd_misaligned no_axi", 64'(ar_hi + aw_hi + w_hi), 64'd0);
      check("rd_misaligned araddr_held", 64'(axi_araddr), 64'h100);
      do_req("wr_misaligned", 1, 32'h0000_0006, 32'h1, 4'hF, 32'h0, 1, 1);
      check("wr_misaligned no_axi", 64'(ar_hi + aw_hi + w_hi), 64'd0);

      // reset while waiting in RD_DATA
      set_slave(0, 20, 0, 0, 0, 32'h9999_9999, 2'b00, 2'b00);
      clear_obs();
      wait_ready("rst_mid", ok);
      if (ok) begin
         issue(0, 32'h0000_0020, 32'h0, 4'h0);
         found = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (axi_rready) begin found = 1; break; end
         end
         check("rst_mid reached_rd_data", 64'(found), 64'd1);
         #1 rst = 1;
         #1;
         check("rst_mid valids", 64'({axi_arvalid, axi_awvalid, axi_wvalid}), 64'd0);
         check("rst_mid readys", 64'({axi_rready, axi_bready}), 64'd0);
         check("rst_mid resp_valid", 64'(resp_valid), 64'd0);
         repeat (2) @(negedge clk);
         rst = 0;
         clear_obs();
         repeat (10) @(negedge clk);
         #1;
         check("rst_mid no_resp", 64'(resp_cnt), 64'd0);
         check("rst_mid req_ready", 64'(req_ready), 64'd1);
      end

      // normal read after the aborted one
      set_slave(0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 2'b00);
      do_req("rd_after_rst", 0, 32'h0000_0040, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 4);
      check("rd_after_rst araddr_at_hs", 64'(ar_hs_addr), 64'h40);

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_axi_master.md
Name: core_axi_master

Overview:
- Sits between the core's load/store unit and the core-side AXI4-Lite port of the memory/UART address router; it is the master that drives core_axi_*.
- Converts one simple single-beat request (read or write) into a compliant AXI4-Lite transaction and returns a one-cycle response pulse with data and status.
- Handles one transaction at a time, with no outstanding transactions.
- Word-aligned accesses only; misaligned requests are rejected locally without touching the bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and accepting.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables, write only.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  completion status.
- axi_araddr out ADDR_W; axi_arvalid out 1; axi_arready in 1.
- axi_rdata in DATA_W; axi_rresp in 2; axi_rvalid in 1; axi_rready out 1.
- axi_awaddr out ADDR_W; axi_awvalid out 1; axi_awready in 1.
- axi_wdata out DATA_W; axi_wstrb out DATA_W/8; axi_wvalid out 1; axi_wready in 1.
- axi_bresp in 2; axi_bvalid in 1; axi_bready out 1.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; req_ready=1.
  - All *valid/*ready outputs 0; resp_valid=0, resp_err=0, resp_rdata=0.
  - All address, data and strobe outputs 0.
  - Reset asserted mid-transaction abandons it immediately; no response is produced.
- Request acceptance: req_ready = (state==IDLE) and resp_valid==0. A request is accepted when req_valid && req_ready. All req_* fields are latched on acceptance; later input changes are ignored.
- Misaligned request (req_addr[1:0]!=0):
  - Next cycle resp_valid=1, resp_err=1, rdata=0; no AXI signal toggles.
  - Back to IDLE.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- Read:
  - IDLE->RD_ADDR: arvalid=1, araddr=latched addr.
  - RD_ADDR: hold arvalid and araddr stable until arready sampled 1. Then arvalid=0, rready=1, go to RD_DATA.
  - RD_DATA: on rvalid&&rready: rready=0, resp_rdata=rdata, resp_err=rresp[1]. If rresp[1]=1, resp_rdata=0. Go to RESP.
- Write:
  - IDLE->WR_REQ: awvalid=1 and wvalid=1 in the same cycle; awaddr, wdata and wstrb driven from the latched request.
  - Internal flags aw_done and w_done track each handshake.
  - awvalid drops the cycle after its own handshake; wvalid likewise. They are independent, in either order or simultaneous.
  - A valid is never dropped before its handshake, and its payload is never changed while valid is high.
  - When both flags are set (same cycle allowed): bready=1, go to WR_RESP.
  - WR_RESP: on bvalid&&bready: bready=0, resp_err=bresp[1], resp_rdata=0, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency:
  - Minimum read, with arready and rvalid asserted as early as possible: 4 cycles from acceptance to resp_valid.
  - Minimum write: 4 cycles.
  - Misaligned reject: 1 cycle.
- Back-to-back: a new request can be accepted the cycle after resp_valid.
- No timeout: the block waits indefinitely on a stalled slave.
- Response outputs resp_rdata and resp_err hold their value until the next completion.

Test Plan:
- Read, addr=0x00000010, slave arready=1 and rvalid=1 with rdata=0xDEADBEEF and rresp=0 -> araddr=0x10 during the arvalid handshake; resp_valid pulses once; resp_rdata=0xDEADBEEF; resp_err=0; arvalid is high for exactly 1 cycle.
- Write, addr=0xFF000004, wdata=0x41, wstrb=0xF; awready delayed 3 cycles, wready immediate; bresp=0 -> wvalid drops first; awvalid stays high until its handshake; bready rises only after both handshakes; single resp_valid pulse with resp_err=0.
- Read with rresp=2'b10 -> resp_err=1, resp_rdata=0.
- Write with bresp=2'b11 -> resp_err=1.
- Misaligned read, addr=0x00000003 -> resp_valid one cycle after acceptance with resp_err=1; arvalid never asserts.
- rst pulsed while in RD_DATA -> all AXI valid/ready outputs 0 in the same cycle (async); no resp_valid; next read completes normally.
